// File: rtl/frame_receiver.sv
// Frame receiver: keeps the leading DESIRED_FRAME_SIZE samples of each FRAME_SIZE frame
// and buffers them, with sof/eof tags, in a small FIFO for a ready/valid consumer.
module frame_receiver #(
  parameter int INPUT_ELEMENTS     = 4,
  parameter int DATA_ELEMENTS      = 2,
  parameter int INPUT_DATA_WIDTH   = 16,
  parameter int FRAME_SIZE         = 2048,
  parameter int DESIRED_FRAME_SIZE = 2000,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     enable,
  input  logic                                                     in_valid,
  input  logic                                                     in_sof,
  input  logic [INPUT_ELEMENTS*DATA_ELEMENTS*INPUT_DATA_WIDTH-1:0] in_data,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [INPUT_ELEMENTS*DATA_ELEMENTS*INPUT_DATA_WIDTH-1:0] out_data,
  output logic                                                     out_sof,
  output logic                                                     out_eof,
  output logic [15:0]                                              frame_count,
  output logic [15:0]                                              drop_count,
  output logic                                                     overflow,
  output logic                                                     short_frame
);

  localparam int W  = INPUT_ELEMENTS * DATA_ELEMENTS * INPUT_DATA_WIDTH;
  localparam int IW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_SIZE - 1);
  localparam logic [IW-1:0] KEEP_LAST = IW'(DESIRED_FRAME_SIZE - 1);
  localparam bit SKIP_NEEDED = (DESIRED_FRAME_SIZE != FRAME_SIZE);

  typedef enum logic [1:0] {IDLE, ACTIVE, SKIP} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [IW-1:0] cur_idx;
  logic          strobe;
  logic          restart;
  logic          keep;
  logic          tag_sof;
  logic          tag_eof;

  // FIFO storage: tags sit above the data bits
  logic [W+1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [W+1:0]  rd_entry;
  logic          full;
  logic          pop;
  logic          push;

  logic [15:0]   frame_count_reg;
  logic [15:0]   drop_count_reg;
  logic          overflow_reg;
  logic          short_frame_reg;

  assign strobe  = enable && in_valid;
  // An in_sof mid-frame abandons the partial frame and starts over at index 0
  assign restart = strobe && in_sof && (state_reg != IDLE) && (idx_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    keep       = 1'b0;
    cur_idx    = idx_reg;
    if (strobe) begin
      if (state_reg == IDLE) begin
        if (in_sof) begin
          keep    = 1'b1;
          cur_idx = '0;
        end
      end else if (restart || state_reg == ACTIVE) begin
        keep    = 1'b1;
        cur_idx = restart ? '0 : idx_reg;
      end
      if (state_reg != IDLE || in_sof) begin
        idx_next = (cur_idx == LAST_IDX) ? '0 : cur_idx + IW'(1);
        if (keep) begin
          state_next = (SKIP_NEEDED && cur_idx == KEEP_LAST) ? SKIP : ACTIVE;
        end else begin
          state_next = (cur_idx == LAST_IDX) ? ACTIVE : SKIP;
        end
      end
    end
  end

  assign tag_sof = keep && (cur_idx == '0);
  assign tag_eof = keep && (cur_idx == KEEP_LAST);

  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push      = keep && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {tag_eof, tag_sof, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_entry = mem[rd_ptr_reg];
  assign out_data = rd_entry[W-1:0];
  // Tags are gated so stale memory contents never show after reset
  assign out_sof  = out_valid && rd_entry[W];
  assign out_eof  = out_valid && rd_entry[W+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_reg <= '0;
      drop_count_reg  <= '0;
      overflow_reg    <= 1'b0;
      short_frame_reg <= 1'b0;
    end else begin
      if (push && tag_eof) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
      if (keep && !push) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end
      if (restart) begin
        short_frame_reg <= 1'b1;
      end
    end
  end

  assign frame_count = frame_count_reg;
  assign drop_count  = drop_count_reg;
  assign overflow    = overflow_reg;
  assign short_frame = short_frame_reg;

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed scenarios plus randomized traffic
// compared against a frame-position/queue reference model.
module tb_frame_receiver;

  localparam int IE    = 2;
  localparam int DE    = 2;
  localparam int IDW   = 8;
  localparam int W     = IE * DE * IDW;
  localparam int F     = 8;
  localparam int D     = 6;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sof;
  logic         out_eof;
  logic [15:0]  frame_count;
  logic [15:0]  drop_count;
  logic         overflow;
  logic         short_frame;

  always #5 clk = ~clk;

  frame_receiver #(
    .INPUT_ELEMENTS(IE), .DATA_ELEMENTS(DE), .INPUT_DATA_WIDTH(IDW),
    .FRAME_SIZE(F), .DESIRED_FRAME_SIZE(D), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .frame_count(frame_count),
    .drop_count(drop_count), .overflow(overflow), .short_frame(short_frame)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         sof;
    logic         eof;
  } item_t;

  // Reference model: synced flag + position within frame; kept iff position < D
  item_t m_q[$];
  item_t got_q[$];
  item_t exp_q[$];
  bit    m_sync;
  int    m_pos;
  int    m_frames;
  int    m_drops;
  bit    m_ovf;
  bit    m_short;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    m_q.delete();
    got_q.delete();
    exp_q.delete();
    m_sync   = 1'b0;
    m_pos    = 0;
    m_frames = 0;
    m_drops  = 0;
    m_ovf    = 1'b0;
    m_short  = 1'b0;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Drive one cycle at the falling edge, log observed/expected pops, advance the model
  task automatic cycle(input bit en, input bit v, input bit s, input logic [W-1:0] d, input bit rdy);
    item_t it;
    bit    pop;
    bit    room;
    enable    = en;
    in_valid  = v;
    in_sof    = s;
    in_data   = d;
    out_ready = rdy;
    if (out_valid && rdy) begin
      it.data = out_data;
      it.sof  = out_sof;
      it.eof  = out_eof;
      got_q.push_back(it);
    end
    pop  = (m_q.size() != 0) && rdy;
    room = (m_q.size() < DEPTH) || pop;
    if (pop) exp_q.push_back(m_q.pop_front());
    if (en && v) begin
      if (s) begin
        if (m_sync && m_pos != 0) m_short = 1'b1;
        m_sync = 1'b1;
        m_pos  = 0;
      end
      if (m_sync) begin
        if (m_pos < D) begin
          it.data = d;
          it.sof  = (m_pos == 0);
          it.eof  = (m_pos == D - 1);
          if (room) begin
            m_q.push_back(it);
            if (it.eof) m_frames++;
          end else begin
            m_ovf = 1'b1;
            if (m_drops < 16'hFFFF) m_drops++;
          end
        end
        m_pos = (m_pos + 1) % F;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++;
    if (out_sof !== 1'b0 || out_eof !== 1'b0) begin errors++; $display("FAIL reset_tags got %b%b expected 00", out_sof, out_eof); end
    checks++;
    if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d expected 0/0", frame_count, drop_count);
    end
    checks++;
    if (overflow !== 1'b0 || short_frame !== 1'b0) begin
      errors++; $display("FAIL reset_flags got %b%b expected 00", overflow, short_frame);
    end
    $display("test_reset done");
  endtask

  task automatic test_continuous();
    int exp_data [12] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13};
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, (i == 0), W'(i), 1'b1);
    drain(6);
    checks++;
    if (got_q.size() != 12) begin errors++; $display("FAIL cont_len got %0d expected 12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      checks++;
      if (got_q[i].data !== W'(exp_data[i]) || got_q[i].sof !== (i == 0 || i == 6) ||
          got_q[i].eof !== (i == 5 || i == 11)) begin
        errors++;
        $display("FAIL cont_item%0d got %0h sof%b eof%b expected %0h", i, got_q[i].data,
                 got_q[i].sof, got_q[i].eof, exp_data[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL cont_frames got %0d expected 2", frame_count); end
    $display("test_continuous done");
  endtask

  task automatic test_no_sof();
    apply_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, 1'b0, W'(i), 1'b1);
    cycle(1'b1, 1'b1, 1'b1, W'(32'h10), 1'b1);
    drain(4);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL nosof_len got %0d expected 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0].data !== W'(32'h10) || got_q[0].sof !== 1'b1) begin
        errors++; $display("FAIL nosof_item got %0h sof%b expected 10 sof1", got_q[0].data, got_q[0].sof);
      end
    end
    $display("test_no_sof done");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, (i == 0), W'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(0) || out_sof !== 1'b1) begin
        errors++; $display("FAIL ovf_stall got v%b %0h sof%b expected v1 0 sof1", out_valid, out_data, out_sof);
      end
    end
    checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd2 || frame_count !== 16'd0) begin
      errors++; $display("FAIL ovf_flags got ovf%b drop%0d frames%0d expected ovf1 drop2 frames0",
                         overflow, drop_count, frame_count);
    end
    drain(6);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL ovf_len got %0d expected 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i].data !== W'(i) || got_q[i].eof !== 1'b0) begin
        errors++; $display("FAIL ovf_item%0d got %0h eof%b expected %0h eof0", i, got_q[i].data, got_q[i].eof, i);
      end
    end
    $display("test_overflow done");
  endtask

  task automatic test_short_frame();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, (i == 0), W'(i), 1'b1);
    cycle(1'b1, 1'b1, 1'b1, W'(32'h20), 1'b1);
    checks++;
    if (short_frame !== 1'b1 || frame_count !== 16'd0) begin
      errors++; $display("FAIL short_flag got sf%b frames%0d expected sf1 frames0", short_frame, frame_count);
    end
    for (int i = 1; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, W'(32'h20 + i), 1'b1);
    drain(4);
    checks++;
    if (got_q.size() !== exp_q.size() || got_q.size() != 9) begin
      errors++; $display("FAIL short_len got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL short_item%0d got %0h expected %0h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_count !== 16'(m_frames)) begin
      errors++; $display("FAIL short_frames got %0d expected %0d", frame_count, m_frames);
    end
    $display("test_short_frame done");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle(1'b1, 1'b1, 1'b1, W'(32'hA), 1'b0);
    cycle(1'b1, 1'b1, 1'b0, W'(32'hB), 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b expected 1", out_valid); end
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || frame_count !== 16'd0 || drop_count !== 16'd0 ||
        overflow !== 1'b0 || short_frame !== 1'b0) begin
      errors++; $display("FAIL mid_cleared got v%b f%0d d%0d o%b s%b expected all 0",
                         out_valid, frame_count, drop_count, overflow, short_frame);
    end
    cycle(1'b1, 1'b1, 1'b0, W'(32'h77), 1'b1);
    drain(3);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL mid_discard got %0d items expected 0", got_q.size()); end
    $display("test_reset_mid done");
  endtask

  task automatic test_enable();
    apply_reset();
    cycle(1'b1, 1'b1, 1'b1, W'(0), 1'b0);
    cycle(1'b1, 1'b1, 1'b0, W'(1), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, W'(32'h99), 1'b1);
    checks++;
    if (got_q.size() != 2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL en_drain got %0d items v%b expected 2 v0", got_q.size(), out_valid);
    end
    for (int i = 2; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, W'(i), 1'b1);
    drain(3);
    checks++;
    if (got_q.size() != 6 || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL en_len got %0d expected 6", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL en_item%0d got %0h expected %0h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL en_frames got %0d expected 1", frame_count); end
    $display("test_enable done");
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
            W'($urandom), ($urandom_range(0, 2) != 0));
      checks++;
      if (out_valid !== (m_q.size() != 0) ||
          (m_q.size() != 0 && (out_data !== m_q[0].data || out_sof !== m_q[0].sof || out_eof !== m_q[0].eof))) begin
        errors++;
        if (errors < 20) $display("FAIL rand_out cyc%0d got v%b %0h expected v%b", c, out_valid, out_data, m_q.size() != 0);
      end
      checks++;
      if (frame_count !== 16'(m_frames) || drop_count !== 16'(m_drops) ||
          overflow !== m_ovf || short_frame !== m_short) begin
        errors++;
        if (errors < 20) $display("FAIL rand_stat cyc%0d got f%0d d%0d o%b s%b expected f%0d d%0d o%b s%b", c,
                                  frame_count, drop_count, overflow, short_frame, m_frames, m_drops, m_ovf, m_short);
      end
    end
    drain(6);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_len got %0d expected %0d", got_q.size(), exp_q.size());
    end
    $display("test_random done: %0d samples out, %0d frames", got_q.size(), m_frames);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_no_sof();
    test_overflow();
    test_short_frame();
    test_reset_mid();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have parameter INPUT_ELEMENTS, default 4, number of antenna channels.
REQ-002 SHALL have parameter DATA_ELEMENTS, default 2, components per channel sample (I, Q).
REQ-003 SHALL have parameter INPUT_DATA_WIDTH, default 16, bits per component.
REQ-004 SHALL have parameter FRAME_SIZE, default 2048, valid samples per received frame.
REQ-005 SHALL have parameter DESIRED_FRAME_SIZE, default 2000, leading samples kept per frame (1..FRAME_SIZE).
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of 2, >=2).
REQ-007 SHALL have port clk  input  1  rising-edge clock.
REQ-008 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port enable  input  1  when low, input samples ignored, frame counters hold.
REQ-010 SHALL have port in_valid  input  1  in_data carries a sample this cycle.
REQ-011 SHALL have port in_sof  input  1  qualifies in_valid sample as frame index 0.
REQ-012 SHALL have port in_data  input  W=INPUT_ELEMENTS*DATA_ELEMENTS*INPUT_DATA_WIDTH  channel 0 in LSBs, component 0 lowest within channel.
REQ-013 SHALL have port out_valid  output  1  out_data holds a buffered sample.
REQ-014 SHALL have port out_ready  input  1  consumer accepts sample when out_valid high.
REQ-015 SHALL have port out_data  output  W  buffered sample.
REQ-016 SHALL have port out_sof  output  1  out_data is kept-sample index 0.
REQ-017 SHALL have port out_eof  output  1  out_data is kept-sample index DESIRED_FRAME_SIZE-1.
REQ-018 SHALL have port frame_count  output  16  completed kept frames, wraps modulo 2^16.
REQ-019 SHALL have port drop_count  output  16  samples lost to full FIFO, saturates at 0xFFFF.
REQ-020 SHALL have port overflow  output  1  sticky: any sample lost to full FIFO.
REQ-021 SHALL have port short_frame  output  1  sticky: in_sof arrived while in ACTIVE or SKIP before index FRAME_SIZE-1.

Function
REQ-022 SHALL accept a sample (strobe) only when enable=1 and in_valid=1.
REQ-023 SHALL implement states IDLE, ACTIVE, SKIP.
REQ-024 IDLE: strobes without in_sof discarded; strobe with in_sof -> index 0 kept, state ACTIVE, sample index becomes 1.
REQ-025 ACTIVE: each strobe kept at current index; strobe at index DESIRED_FRAME_SIZE-1 -> SKIP (or, if DESIRED_FRAME_SIZE=FRAME_SIZE, index wraps to 0, stay ACTIVE).
REQ-026 SKIP: strobes discarded; strobe at index FRAME_SIZE-1 -> index 0, ACTIVE (back-to-back frames need no in_sof).
REQ-027 Strobe with in_sof in ACTIVE or SKIP at index !=0 SHALL restart at index 0 (sample kept, out_sof tagged), set short_frame; partial frame gets no out_eof, frame_count unchanged.
REQ-028 Sample index counter SHALL be ceil(log2(FRAME_SIZE)) bits, wrapping FRAME_SIZE-1 -> 0.
REQ-029 Kept sample SHALL be pushed with sof/eof tags; frame_count increments on the cycle the eof-tagged sample is pushed successfully.
REQ-030 Push SHALL succeed if FIFO not full, or full with a pop in the same cycle.
REQ-031 Failed push: sample lost, overflow set, drop_count +1 (saturating); index/state advance as if pushed; lost eof sample does not increment frame_count.
REQ-032 Latency: sample pushed on edge N SHALL be visible at out_valid/out_data after edge N (cycle N+1); no combinational in->out path.
REQ-033 Pop on out_valid&&out_ready; out_data/out_sof/out_eof SHALL be stable while out_valid&&!out_ready.
REQ-034 FIFO empty -> out_valid=0; out_ready ignored.
REQ-035 enable=0 SHALL NOT block pops.

Reset
REQ-036 reset SHALL clear state to IDLE, index 0, FIFO empty, out_valid=0, out_sof=0, out_eof=0, frame_count=0, drop_count=0, overflow=0, short_frame=0; out_data value don't-care.
REQ-037 reset mid-frame SHALL discard buffered samples; next strobe without in_sof discarded.

Verification (FRAME_SIZE=8, DESIRED_FRAME_SIZE=6, FIFO_DEPTH=4, out_ready=1 unless stated)
REQ-038 in_sof + 16 consecutive strobes data 0..15 -> out 0..5 then 8..13; out_sof on 0,8; out_eof on 5,13; frame_count=2; 6,7,14,15 absent.
REQ-039 3 strobes without in_sof, then in_sof strobe data 0x10 -> only 0x10 output, out_sof=1.
REQ-040 out_ready=0, in_sof + 6 strobes -> 4 stored, overflow=1, drop_count=2, frame_count=0; out_ready=1 -> samples 0..3 drain in order.
REQ-041 in_sof at index 3 of ACTIVE frame -> short_frame=1, new out_sof, no out_eof for old frame, frame_count unchanged.
REQ-042 Reset asserted with 2 entries buffered -> next cycle out_valid=0, all counters/flags 0, state IDLE.
REQ-043 enable=0 for 5 cycles mid-frame with in_valid=1 -> no samples taken, index held; pending FIFO entries still drain.
